// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory responder for the MA stage. Accepts one request at a time over a
// valid/ready handshake, waits LATENCY cycles, performs the load or byte-masked
// store against an internal word memory, and returns a response held until the
// requester takes it. Misaligned or out-of-range addresses are rejected with
// rsp_err=1 and never touch memory.
//
// Parameters
//   ADDR_W   log2 of memory depth in 32-bit words
//   LATENCY  wait cycles between acceptance and response (0..15)
//
// Ports
//   clk        clock, rising-edge
//   reset      asynchronous active-low reset
//   req_valid  request present            req_ready  responder idle
//   req_we     1 = store, 0 = load        req_addr   byte address
//   req_wdata  store data                 req_wstrb  store byte-lane enables
//   rsp_valid  response present           rsp_ready  requester takes response
//   rsp_rdata  load data (0 otherwise)    rsp_err    request rejected
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, next_state;
    logic [3:0] cnt;

    logic accept;
    logic enter_resp;
    logic leave_resp;

    logic              req_err;
    logic [ADDR_W-1:0] req_idx;

    logic              cap_we;
    logic              cap_err;
    logic [ADDR_W-1:0] cap_idx;
    logic [31:0]       cap_wdata;
    logic [3:0]        cap_wstrb;

    logic              op_we;
    logic              op_err;
    logic [ADDR_W-1:0] op_idx;
    logic [31:0]       op_wdata;
    logic [3:0]        op_wstrb;
    logic              mem_we;

    // Power-up contents are zero; reset never clears the array.
    logic [31:0] mem [DEPTH] = '{default: '0};

    assign req_idx = req_addr[ADDR_W+1:2];
    assign req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_W + 2)) != 32'd0);

    // With zero latency the memory operation happens on the accepting edge,
    // so it must use the live request rather than the captured copy.
    assign op_we    = (LATENCY == 0) ? req_we    : cap_we;
    assign op_err   = (LATENCY == 0) ? req_err   : cap_err;
    assign op_idx   = (LATENCY == 0) ? req_idx   : cap_idx;
    assign op_wdata = (LATENCY == 0) ? req_wdata : cap_wdata;
    assign op_wstrb = (LATENCY == 0) ? req_wstrb : cap_wstrb;

    // The reset term stops a write on an edge that arrives while reset is held.
    assign mem_we = enter_resp && op_we && !op_err && reset;

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        leave_resp = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        next_state = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                    leave_resp = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Control state and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_err   <= op_err;
                rsp_rdata <= (op_err || op_we) ? 32'd0 : mem[op_idx];
            end else if (leave_resp) begin
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Request capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we    <= req_we;
            cap_err   <= req_err;
            cap_idx   <= req_idx;
            cap_wdata <= req_wdata;
            cap_wstrb <= req_wstrb;
        end
    end

    // Memory write on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (op_wstrb[b]) begin
                    mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving log2 of the data memory depth in 32-bit words (256 words).
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 0..15, giving the number of wait cycles between request acceptance and response.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the MA stage presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address (normally the ALU result).
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data (normally op2).
REQ-010 The block SHALL have port req_wstrb, input, 4 bits: store byte enables; bit i enables byte lane i.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the MA stage accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: load data.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the request was rejected.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, WAIT and RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0 (one outstanding request, no pipelining).
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_we, req_addr, req_wdata and req_wstrb SHALL be captured at that edge.
REQ-018 On acceptance, the FSM SHALL go to WAIT with a down-counter loaded with LATENCY-1 when LATENCY>0, or go directly to RESP when LATENCY=0.
REQ-019 In WAIT, the counter SHALL decrement once per cycle, and the FSM SHALL go to RESP on the edge at which the counter equals 0.
REQ-020 rsp_valid SHALL first be 1 in the cycle following the (LATENCY+1)th rising edge counted from, and including, the accepting edge.
REQ-021 The memory operation SHALL execute on the edge that enters RESP: the load read data is registered into rsp_rdata and the store write is committed at that same edge.
REQ-022 The word index SHALL be addr[ADDR_W+1:2].
REQ-023 A request SHALL be an error when addr[1:0]!=0 (misaligned) or addr[31:ADDR_W+2]!=0 (out of range).
REQ-024 An error request SHALL not write memory, SHALL set rsp_rdata=0 and SHALL set rsp_err=1.
REQ-025 A store SHALL write only the byte lanes selected by wstrb; wstrb=4'b0000 SHALL write nothing and still produce a normal response.
REQ-026 A store response SHALL have rsp_rdata=0 and rsp_err=0.
REQ-027 A load response SHALL have rsp_rdata equal to mem[index] and rsp_err=0.
REQ-028 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until an edge with rsp_ready=1; at that edge the FSM SHALL return to IDLE and rsp_valid SHALL fall.
REQ-029 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-030 A load issued after a store to the same word SHALL return the stored data (read-after-write).
REQ-031 Minimum cost per transaction SHALL be LATENCY+2 cycles when rsp_ready is held at 1.

Reset
REQ-032 While reset=0, the FSM SHALL be in IDLE, the counter SHALL be 0, and the outputs SHALL be req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-033 Reset asserted in WAIT SHALL discard the pending request, and a pending store SHALL not be written.
REQ-034 Reset asserted in RESP SHALL drop the response.
REQ-035 Memory contents SHALL not be affected by reset and SHALL be 0 at time zero.

Verification
REQ-036 The bench SHALL cover: LATENCY=2, store addr 0x10 wdata 0xDEADBEEF wstrb 4'hF, then load 0x10 -> rsp_valid 3 cycles after each accept, load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 The bench SHALL cover: after the previous scenario, store 0x10 wdata 0x000000AA wstrb 4'b0001, then load 0x10 -> rsp_rdata=0xDEADBEAA.
REQ-038 The bench SHALL cover: load 0x12 (misaligned) and load 0x400 (out of range) -> rsp_err=1, rsp_rdata=0; store 0x401 -> rsp_err=1 and memory unchanged.
REQ-039 The bench SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; a new req_valid in that window is not accepted.
REQ-040 The bench SHALL cover: store 0x20 wdata 0x12345678, then reset pulsed low during WAIT -> IDLE outputs immediately; a subsequent load 0x20 returns 0x00000000.
REQ-041 The bench SHALL cover: LATENCY=0, back-to-back loads with rsp_ready=1 -> one response every 2 cycles, each rsp_valid in the cycle after acceptance.
